// File: rtl/hazard_ctrl.sv
// hazard_ctrl: in-flight destination scoreboard driving distance-coded forwarding,
// load-use stalls, multi-cycle branch flushes and a saturating stall counter.
module hazard_ctrl #(
   parameter int AWIDTH       = 5,
   parameter int DEPTH        = 3,
   parameter int LOAD_LAT     = 1,
   parameter int FLUSH_CYCLES = 2,
   localparam int SW          = $clog2(DEPTH + 1)
) (
   input  logic              hc_clk,
   input  logic              hc_rst,
   input  logic              hc_i_issue_valid,
   input  logic [AWIDTH-1:0] hc_i_addr_rs,
   input  logic [AWIDTH-1:0] hc_i_addr_rt,
   input  logic              hc_i_use_rs,
   input  logic              hc_i_use_rt,
   input  logic              hc_i_wr_en,
   input  logic [AWIDTH-1:0] hc_i_addr_rd,
   input  logic              hc_i_is_load,
   input  logic              hc_i_branch_taken,
   output logic              hc_o_issue,
   output logic              hc_o_stall,
   output logic              hc_o_flush,
   output logic [SW-1:0]     hc_o_fwd_rs,
   output logic [SW-1:0]     hc_o_fwd_rt,
   output logic [15:0]       hc_o_stall_cnt
);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   logic [DEPTH-1:0]  sb_valid, sb_load;
   logic [AWIDTH-1:0] sb_rd [DEPTH];
   logic [FW-1:0]     flush_cnt;
   logic [SW-1:0]     dist_rs, dist_rt;
   logic              load_rs, load_rt, hazard;

   // Scan from the deepest entry up so the nearest producer overrides older ones.
   always_comb begin
      dist_rs = '0;
      dist_rt = '0;
      load_rs = 1'b0;
      load_rt = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (hc_i_use_rs && hc_i_addr_rs != '0 && sb_valid[k] && sb_rd[k] == hc_i_addr_rs) begin
            dist_rs = SW'(k + 1);
            load_rs = sb_load[k];
         end
         if (hc_i_use_rt && hc_i_addr_rt != '0 && sb_valid[k] && sb_rd[k] == hc_i_addr_rt) begin
            dist_rt = SW'(k + 1);
            load_rt = sb_load[k];
         end
      end
   end

   assign hazard     = (load_rs && int'(dist_rs) <= LOAD_LAT) || (load_rt && int'(dist_rt) <= LOAD_LAT);
   assign hc_o_flush = hc_i_branch_taken || flush_cnt != '0;
   assign hc_o_stall = hazard && hc_i_issue_valid && !hc_o_flush;
   assign hc_o_issue = hc_i_issue_valid && !hc_o_stall && !hc_o_flush;

   always_ff @(posedge hc_clk or posedge hc_rst) begin
      if (hc_rst) begin
         sb_valid       <= '0;
         sb_load        <= '0;
         for (int k = 0; k < DEPTH; k++) sb_rd[k] <= '0;
         flush_cnt      <= '0;
         hc_o_fwd_rs    <= '0;
         hc_o_fwd_rt    <= '0;
         hc_o_stall_cnt <= '0;
      end else begin
         sb_valid       <= {sb_valid[DEPTH-2:0], hc_o_issue && hc_i_wr_en && hc_i_addr_rd != '0};
         sb_load        <= {sb_load[DEPTH-2:0], hc_i_is_load};
         sb_rd[0]       <= hc_i_addr_rd;
         for (int k = 1; k < DEPTH; k++) sb_rd[k] <= sb_rd[k-1];
         flush_cnt      <= hc_i_branch_taken ? FW'(FLUSH_CYCLES - 1) : (flush_cnt != '0 ? flush_cnt - 1'b1 : '0);
         hc_o_fwd_rs    <= hc_o_issue ? dist_rs : '0;
         hc_o_fwd_rt    <= hc_o_issue ? dist_rt : '0;
         hc_o_stall_cnt <= (hc_o_stall && hc_o_stall_cnt != 16'hFFFF) ? hc_o_stall_cnt + 16'd1 : hc_o_stall_cnt;
      end
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the MIPS pipeline. It replaces fixed EX/MEM-only forwarding with a scoreboard of in-flight destination registers across DEPTH stages. It generates distance-coded forwarding selects, load-use stalls with a configurable load latency, multi-cycle branch flushes and a stall performance counter. It sits beside the decode stage and drives the decode/execute pipeline register's hold/bubble controls and the execute-stage operand muxes.

## Interface
- AWIDTH, 5: register address width.
- DEPTH, 3: number of tracked in-flight stages after issue (EX..WB); minimum 2.
- LOAD_LAT, 1: load data is first forwardable at distance LOAD_LAT+1; range 0..DEPTH-1.
- FLUSH_CYCLES, 2: cycles hc_o_flush stays high per taken branch; minimum 1.
- SW (localparam) = $clog2(DEPTH+1): forwarding select width.

Ports:
- hc_clk  in  1  clock; all state updates on rising edge.
- hc_rst  in  1  reset, asynchronous and active-high; clears all state.
- hc_i_issue_valid  in  1  decode holds a valid instruction.
- hc_i_addr_rs, hc_i_addr_rt  in  AWIDTH  source registers of the decode instruction.
- hc_i_use_rs, hc_i_use_rt  in  1  source actually read.
- hc_i_wr_en  in  1  decode instruction writes a register.
- hc_i_addr_rd  in  AWIDTH  its destination (already rt/rd-muxed).
- hc_i_is_load  in  1  decode instruction is a load.
- hc_i_branch_taken  in  1  branch resolved taken in EX this cycle.
- hc_o_issue  out  1  decode instruction advances this cycle.
- hc_o_stall  out  1  hold PC/fetch/decode; insert bubble into EX.
- hc_o_flush  out  1  kill fetch/decode contents.
- hc_o_fwd_rs, hc_o_fwd_rt  out  SW  registered operand source for the instruction now in EX: 0 = register-file value, d = result of producer d stages ahead.
- hc_o_stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Scoreboard: DEPTH entries {valid, rd, is_load}; entry k holds the instruction at distance k+1 ahead of the decode instruction. Each cycle entry[k] <= entry[k-1]. entry[0] <= {hc_i_wr_en && hc_i_addr_rd!=0, hc_i_addr_rd, hc_i_is_load} if hc_o_issue, else invalid (bubble).
- Match (per source, combinational): use bit set, address != 0, entry valid, rd equal. The nearest (lowest k) match wins; distance d = k+1.
- Load-use: nearest match is_load and d <= LOAD_LAT -> hazard.
- hc_o_flush = hc_i_branch_taken || flush_cnt != 0. On taken, flush_cnt <= FLUSH_CYCLES-1 (reload if already running); otherwise it decrements to 0.
- hc_o_stall = (load-use hazard on rs or rt) && hc_i_issue_valid && !hc_o_flush. Flush has priority.
- hc_o_issue = hc_i_issue_valid && !hc_o_stall && !hc_o_flush.
- hc_o_fwd_rs/rt <= d of nearest match (0 if none) when hc_o_issue; <= 0 otherwise.
- A match deeper than DEPTH is invisible; the register file is assumed written by then, with write-before-read.
- hc_o_stall_cnt increments on each cycle hc_o_stall=1 and saturates at 16'hFFFF.

## Timing
- Reset (async, hc_rst=1): entries invalid, flush_cnt=0, hc_o_fwd_rs/rt=0, hc_o_stall_cnt=0. hc_o_issue, hc_o_stall and hc_o_flush follow their combinational inputs; with no inputs they read 0.
- hc_o_issue, hc_o_stall and hc_o_flush are combinational, same cycle as the inputs.
- hc_o_fwd_* is valid one cycle after issue, aligned with the consumer in EX.
- Load-use stall lasts LOAD_LAT-d+1 cycles. The stalled instruction re-evaluates each cycle as bubbles shift the producer deeper.
- Taken branch: flush for FLUSH_CYCLES consecutive cycles including the taken cycle; no issue during them.
- Branch taken while a load-use stall is pending: flush wins, stall=0, and the stalled instruction is killed.
- Reset asserted mid-flush or mid-stall: everything clears immediately; operation resumes on the first edge after deassertion.

## Test plan
- add $3 issued, then add $4,$3,$1 next cycle -> no stall; consumer's EX cycle shows hc_o_fwd_rs=1. With one independent instruction between them -> fwd_rs=2.
- lw $5 then add $6,$5,$5 (LOAD_LAT=1) -> hc_o_stall=1 for exactly 1 cycle with a bubble; then issue with fwd_rs=fwd_rt=2; hc_o_stall_cnt=1.
- Same sequence with LOAD_LAT=2, DEPTH=4 -> 2 stall cycles, then fwd=3; stall_cnt=2.
- Producers write $0, or hc_i_use_rt=0 with a matching rt -> fwd=0 and no stall.
- hc_i_branch_taken pulse with FLUSH_CYCLES=2 while a load-use stall is pending -> flush=1 for 2 cycles, stall=0, issue=0, no entries inserted. A second taken on cycle 2 -> flush extends to cycle 3.
- Drive the stall condition for 70000 cycles -> hc_o_stall_cnt holds 16'hFFFF. Assert hc_rst mid-run -> count=0 and fwd=0 asynchronously, before the next clock edge.
